branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Resolves conditional branches in EX. Drives BrUn to the Branch_Comparator and decodes
//    BrEq/BrLT with funct3 into a taken decision.
//  Owns a 2-bit-counter branch history table (BHT) that gives fetch its prediction.
//  On a mispredict, sequences a PC redirect using a valid/ready handshake, a one-cycle
//    flush pulse and an EX stall. Also keeps branch and mispredict statistics.
// PARAMETERS
//  XLEN       32  datapath/PC width
//  BHT_IDX_W  6   log2(BHT entries); index = pc[BHT_IDX_W+1:2]
//  CNT_W      32  width of statistics counters
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          asynchronous reset, active-high
//  if_pc          in   XLEN       fetch PC for BHT lookup
//  if_pred_taken  out  1          prediction for if_pc (combinational read)
//  br_valid       in   1          EX holds a conditional branch this cycle
//  br_funct3      in   3          branch funct3
//  br_pc          in   XLEN       PC of branch in EX
//  br_target      in   XLEN       computed taken target
//  br_pred_taken  in   1          prediction carried down the pipe with the branch
//  BrUn           out  1          to comparator: 1 = unsigned compare
//  BrEq           in   1          from comparator: rs1 == rs2
//  BrLT           in   1          from comparator: rs1 < rs2 (per BrUn)
//  redir_valid    out  1          redirect request to fetch
//  redir_ready    in   1          fetch accepts redirect
//  redir_pc       out  XLEN       redirect PC
//  flush          out  1          one-cycle kill of IF/ID younger instructions
//  stall          out  1          hold EX/earlier stages
//  br_count       out  CNT_W      legal branches resolved
//  mispred_count  out  CNT_W      mispredicts detected
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; redir_valid=0, flush=0, stall=0, redir_pc=0;
//    counters=0; every BHT entry=2'b01 (weakly not-taken).
//  BrUn = br_funct3[1], combinational.
//  taken, by funct3:
//    000 BEQ  -> BrEq      001 BNE  -> !BrEq
//    100 BLT  -> BrLT      101 BGE  -> !BrLT
//    110 BLTU -> BrLT      111 BGEU -> !BrLT
//  funct3 010/011 are illegal: no redirect, no BHT update, not counted.
//  FSM IDLE: a legal branch is resolved when br_valid=1 at the clock edge.
//    - br_count += 1.
//    - BHT[idx(br_pc)] saturating update: +1 if taken, -1 if not; clamps at 00/11.
//    - mispredict = taken != br_pred_taken. On mispredict:
//        mispred_count += 1; redir_pc <= taken ? br_target : br_pc+4 (mod 2^XLEN);
//        redir_valid <= 1; flush <= 1; go to REDIRECT.
//    - Latency: redir_valid and flush are high in the cycle after the resolving edge.
//  FSM REDIRECT:
//    - stall=1 (combinational from state); flush=1 only in the first REDIRECT cycle.
//    - redir_valid and redir_pc are held stable until the redir_valid&&redir_ready edge,
//      then go to IDLE with redir_valid=0. Accept is possible in the first cycle.
//    - br_valid is ignored: no update, no count.
//  if_pred_taken = BHT[if_pc[BHT_IDX_W+1:2]][1].
//    - A same-cycle lookup and update of one index returns the pre-update value.
//  Counters wrap modulo 2^CNT_W. rst mid-REDIRECT drops redir_valid/stall at once.
// TESTING
//  Reset -> all outputs 0; if_pred_taken=0 for if_pc=0x0 and 0xFC.
//  BEQ pc=0x100 tgt=0x140 BrEq=1 pred=0 -> next cycle redir_valid=1,
//    redir_pc=0x140, flush=1; BHT[0x00] 01->10; counts 1/1.
//  BLTU funct3=110 -> BrUn=1; BrLT=0 pred=0 -> no redirect; BHT 01->00; br_count=1.
//  Mispredict, redir_ready=0 for 3 cycles -> redir_valid/redir_pc stable; stall=1 for 4 cycles;
//    flush high only in cycle 1; br_valid pulses ignored; IDLE after accept.
//  4 taken BGE (BrLT=0) at pc=0x200 -> counter 01->10->11->11->11;
//    if_pc=0x200 gives if_pred_taken=1.
//  rst asserted mid-REDIRECT -> redir_valid=0, stall=0 before next edge; counts=0.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch resolution in EX: taken decode, 2-bit BHT for fetch prediction,
// and a mispredict redirect sequencer with flush/stall and branch statistics.
module branch_resolve_ctrl #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              br_valid,
  input  logic [2:0]        br_funct3,
  input  logic [XLEN-1:0]   br_pc,
  input  logic [XLEN-1:0]   br_target,
  input  logic              br_pred_taken,
  output logic              BrUn,
  input  logic              BrEq,
  input  logic              BrLT,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [XLEN-1:0]   redir_pc,
  output logic              flush,
  output logic              stall,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t                  state;
  logic [1:0]              bht [BHT_N];
  logic                    taken;
  logic                    legal;
  logic                    resolve;
  logic                    mispredict;
  logic [BHT_IDX_W-1:0]    if_idx;
  logic [BHT_IDX_W-1:0]    br_idx;

  assign BrUn   = br_funct3[1];
  assign if_idx = if_pc[BHT_IDX_W+1:2];
  assign br_idx = br_pc[BHT_IDX_W+1:2];

  // Fetch reads the array directly, so a same-cycle update is not yet visible.
  assign if_pred_taken = bht[if_idx][1];

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (br_funct3)
      3'b000:  taken = BrEq;
      3'b001:  taken = !BrEq;
      3'b100:  taken = BrLT;
      3'b101:  taken = !BrLT;
      3'b110:  taken = BrLT;
      3'b111:  taken = !BrLT;
      default: legal = 1'b0;
    endcase
  end

  assign resolve    = (state == IDLE) && br_valid && legal;
  assign mispredict = resolve && (taken != br_pred_taken);
  assign stall      = (state == REDIRECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (resolve) begin
      if (taken && bht[br_idx] != 2'b11)
        bht[br_idx] <= bht[br_idx] + 2'b01;
      else if (!taken && bht[br_idx] != 2'b00)
        bht[br_idx] <= bht[br_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      redir_valid   <= 1'b0;
      redir_pc      <= '0;
      flush         <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      flush <= 1'b0;
      case (state)
        IDLE: begin
          if (resolve) br_count <= br_count + CNT_W'(1);
          if (mispredict) begin
            mispred_count <= mispred_count + CNT_W'(1);
            redir_pc      <= taken ? br_target : br_pc + XLEN'(4);
            redir_valid   <= 1'b1;
            flush         <= 1'b1;
            state         <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
